johnson_seq_ctrl: RTL and testbench

Command-driven controller that owns and sequences a WIDTH-stage Johnson (twisted-ring) counter. The controller supports single steps, a counted run of N full rotations, and a free run that continues until stopped. It also supports direction control and a hold/pause input. It sits between a host command interface and logic that consumes one-hot-decodable Johnson phases, and it reports rotation wraps, completion and rejected commands.

---
 rtl/johnson_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-stage Johnson counter.
// It supports single steps, counted runs of whole rotations, and a free run that continues until stopped.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cycles,
  input  logic             hold,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             cmd_err
);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_FREE = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COUNTED = 2'b01,
    FREE    = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_d, done_d, err_d;
  logic             adv;
  logic             adv_dir;
  logic [WIDTH-1:0] adv_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      remain_q <= '0;
      out_q    <= '0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      remain_q <= remain_d;
      out_q    <= out_d;
      wrap     <= wrap_d;
      done     <= done_d;
      cmd_err  <= err_d;
    end
  end

  // Forward shifts toward bit 0 and feeds ~out[0] into the MSB. Reverse is the mirror image.
  always_comb begin
    if (adv_dir)
      adv_val = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
    else
      adv_val = {~out_q[0], out_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    remain_d = remain_q;
    out_d    = out_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    adv      = 1'b0;
    adv_dir  = dir_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN: begin
              if (cmd_cycles == '0) begin
                done_d = 1'b1;
              end else begin
                state_d  = COUNTED;
                remain_d = cmd_cycles;
                dir_d    = cmd_dir;
              end
            end
            OP_FREE: begin
              state_d = FREE;
              dir_d   = cmd_dir;
            end
            OP_STEP: begin
              dir_d   = cmd_dir;
              adv_dir = cmd_dir;
              adv     = ~hold;
            end
            default: ;
          endcase
        end
      end
      COUNTED, FREE: begin
        // A STOP takes priority over any advance on the same edge, including the final wrap.
        if (cmd_valid && cmd_op == OP_STOP) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          err_d = cmd_valid;
          adv   = ~hold;
        end
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      out_d = adv_val;
      if (adv_val == '0) begin
        wrap_d = 1'b1;
        if (state_q == COUNTED) begin
          remain_d = remain_q - ONE;
          if (remain_q == ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    cmd_ready = 1'b1;
    busy      = (state_q != IDLE);
    out       = out_q;
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Randomized and directed checks of johnson_seq_ctrl.
// The reference model tracks the counter as a phase index around the 2*WIDTH-state ring.
module tb_johnson_seq_ctrl;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_cycles;
  logic             hold;
  logic [W-1:0]     out;
  logic             busy, wrap, done, cmd_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state. mode: 0 idle, 1 counted, 2 free.
  int m_phase, m_mode, m_dir, m_remain;
  int e_wrap, e_done, e_err;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_cycles(cmd_cycles), .hold(hold),
    .out(out), .busy(busy), .wrap(wrap), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] phase_to_out(int p);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (p <= W) v[i] = (i >= W - p);
      else        v[i] = (i < 2*W - p);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_dir = 0; m_remain = 0;
    e_wrap = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_edge(input int v, input int op, input int d, input int cyc, input int h);
    int adv, adir;
    adv = 0; adir = m_dir;
    e_wrap = 0; e_done = 0; e_err = 0;
    if (m_mode == 0) begin
      if (v != 0) begin
        case (op)
          0: if (cyc == 0) e_done = 1;
             else begin m_mode = 1; m_remain = cyc; m_dir = d; end
          1: begin m_mode = 2; m_dir = d; end
          3: begin m_dir = d; adir = d; adv = (h == 0); end
          default: ;
        endcase
      end
    end else if (v != 0 && op == 2) begin
      m_mode = 0;
      e_done = 1;
    end else begin
      e_err = v;
      adv = (h == 0);
    end
    if (adv != 0) begin
      m_phase = (adir != 0) ? (m_phase + 2*W - 1) % (2*W) : (m_phase + 1) % (2*W);
      if (m_phase == 0) begin
        e_wrap = 1;
        if (m_mode == 1) begin
          m_remain--;
          if (m_remain == 0) begin
            m_mode = 0;
            e_done = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    checkOutput({where, ".out"},     32'(out),       32'(phase_to_out(m_phase)));
    checkOutput({where, ".busy"},    32'(busy),      32'(m_mode != 0));
    checkOutput({where, ".wrap"},    32'(wrap),      32'(e_wrap));
    checkOutput({where, ".done"},    32'(done),      32'(e_done));
    checkOutput({where, ".cmd_err"}, 32'(cmd_err),   32'(e_err));
    checkOutput({where, ".ready"},   32'(cmd_ready), 32'd1);
  endtask

  task automatic applyStimulus(input string where, input int v, input int op, input int d,
                               input int cyc, input int h);
    @(negedge clk);
    cmd_valid  = (v != 0);
    cmd_op     = 2'(op);
    cmd_dir    = (d != 0);
    cmd_cycles = CNT_W'(cyc);
    hold       = (h != 0);
    @(posedge clk);
    model_edge(v, op, d, cyc, h);
    #1;
    compare_all(where);
  endtask

  task automatic idle_cycles(input string where, input int n);
    for (int i = 0; i < n; i++) applyStimulus(where, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
    cmd_cycles = '0; hold = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Counted run of two forward rotations from zero.
    applyStimulus("run2", 1, 0, 0, 2, 0);
    idle_cycles("run2", 18);

    // Three reverse steps, then a forward run back through zero.
    for (int i = 0; i < 3; i++) applyStimulus("step", 1, 3, 1, 0, 0);
    applyStimulus("run1", 1, 0, 0, 1, 0);
    idle_cycles("run1", 5);

    // Free run in reverse with a three-cycle hold, then STOP.
    applyStimulus("free", 1, 1, 1, 0, 0);
    idle_cycles("free", 3);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 0, 0, 0, 0, 1);
    idle_cycles("free", 2);
    applyStimulus("stop", 1, 2, 0, 0, 0);
    idle_cycles("stop", 2);

    // Dropped command during a run, then STOP that lands on the final wrap.
    while (m_phase != 0) applyStimulus("align", 1, 3, 0, 0, 0);
    applyStimulus("run3", 1, 0, 0, 3, 0);
    applyStimulus("err", 1, 0, 1, 5, 0);
    idle_cycles("run3", 22);
    applyStimulus("stopwrap", 1, 2, 0, 0, 0);
    idle_cycles("stopwrap", 2);

    // Zero-length run, STOP while idle, and a STEP suppressed by hold.
    applyStimulus("run0", 1, 0, 0, 0, 0);
    applyStimulus("idlestop", 1, 2, 0, 0, 0);
    applyStimulus("stephold", 1, 3, 1, 0, 1);
    idle_cycles("idle", 2);

    // Asynchronous reset in the middle of a free run.
    applyStimulus("free2", 1, 1, 0, 0, 0);
    idle_cycles("free2", 5);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("after_rst", 1, 0, 0, 1, 0);
    idle_cycles("after_rst", 9);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 99) < 25) ? 1 : 0,
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 99) < 20) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
